// File: rtl/ddma_pkg.sv
// rtl/ddma_pkg.sv - shared constants and FSM state type for the DDMA packet sender
package ddma_pkg;
   localparam int SIZE_WIDTH         = 16;
   localparam int DEFAULT_FLIT_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 16;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      FETCH_HDR     = 3'd1,
      WAIT_SIZE     = 3'd2,
      FETCH_PAYLOAD = 3'd3,
      DRAIN         = 3'd4,
      DONE          = 3'd5
   } state_t;
endpackage

// File: rtl/ddma_flit_fifo.sv
// rtl/ddma_flit_fifo.sv - synchronous prefetch FIFO for outgoing flits
module ddma_flit_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (int'(count_q) == DEPTH);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // a push into a full FIFO is still legal when the head leaves in the same cycle
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/ddma_packet_sender.sv
// rtl/ddma_packet_sender.sv - fetches a header/size/payload packet from memory and streams it to a router port
module ddma_packet_sender
   import ddma_pkg::*;
#(
   parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [FLIT_WIDTH-1:0] mem_data,
   output logic                  clock_rx,
   output logic                  rx,
   output logic [FLIT_WIDTH-1:0] data_i,
   input  logic                  credit_o
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  hdr_cnt_q, hdr_cnt_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic [SIZE_WIDTH-1:0] pay_cnt_q, pay_cnt_d;
   logic                  rd_pend_q;
   logic                  rd_is_size_q, rd_is_size_d;

   logic                  fifo_full, fifo_empty, fifo_pop;
   logic [CW-1:0]         fifo_count;
   logic [FLIT_WIDTH-1:0] fifo_head;
   logic                  can_issue, last_accept;

   // the in-flight read already owns a FIFO slot, so overflow is impossible
   assign can_issue   = !fifo_full && ((int'(fifo_count) + int'(rd_pend_q)) < FIFO_DEPTH);
   assign fifo_pop    = rx && credit_o;
   assign last_accept = (state_q == DRAIN) && fifo_pop && !rd_pend_q && (int'(fifo_count) == 1);

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign mem_addr = addr_q;
   assign clock_rx = clock;
   assign rx       = !fifo_empty;
   assign data_i   = fifo_empty ? '0 : fifo_head;

   ddma_flit_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rd_pend_q),
      .push_data (mem_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      hdr_cnt_d    = hdr_cnt_q;
      size_d       = size_q;
      pay_cnt_d    = pay_cnt_q;
      mem_rd       = 1'b0;
      rd_is_size_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d    = base_addr;
               hdr_cnt_d = 1'b0;
               pay_cnt_d = '0;
               state_d   = FETCH_HDR;
            end
         end
         FETCH_HDR: begin
            if (can_issue) begin
               mem_rd    = 1'b1;
               addr_d    = addr_q + 1'b1;
               hdr_cnt_d = 1'b1;
               if (hdr_cnt_q) begin
                  rd_is_size_d = 1'b1;
                  state_d      = WAIT_SIZE;
               end
            end
         end
         WAIT_SIZE: begin
            if (rd_pend_q && rd_is_size_q) begin
               size_d  = mem_data[SIZE_WIDTH-1:0];
               state_d = (mem_data[SIZE_WIDTH-1:0] != '0) ? FETCH_PAYLOAD : DRAIN;
            end
         end
         FETCH_PAYLOAD: begin
            if (can_issue) begin
               mem_rd    = 1'b1;
               addr_d    = addr_q + 1'b1;
               pay_cnt_d = pay_cnt_q + 1'b1;
               if (pay_cnt_q == size_q - 1'b1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_accept) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         hdr_cnt_q    <= 1'b0;
         size_q       <= '0;
         pay_cnt_q    <= '0;
         rd_pend_q    <= 1'b0;
         rd_is_size_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         hdr_cnt_q    <= hdr_cnt_d;
         size_q       <= size_d;
         pay_cnt_q    <= pay_cnt_d;
         rd_pend_q    <= mem_rd;
         rd_is_size_q <= rd_is_size_d;
      end
   end
endmodule

// File: tb/tb_ddma_packet_sender.sv
// tb/tb_ddma_packet_sender.sv - directed self-checking bench for ddma_packet_sender
module tb_ddma_packet_sender;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic        busy, done, mem_rd, clock_rx, rx;
   logic [15:0] mem_addr;
   logic [31:0] mem_data = '0;
   logic [31:0] data_i;
   logic        credit_o = 1'b1;

   ddma_packet_sender dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .busy      (busy),
      .done      (done),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .clock_rx  (clock_rx),
      .rx        (rx),
      .data_i    (data_i),
      .credit_o  (credit_o)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [0:65535];
   logic [31:0] flits [$];
   int          flit_cyc [$];
   logic [15:0] rd_log [$];
   logic [31:0] exp_q [$];
   int checks = 0, errors = 0;
   int cyc = 0, issued = 0, accepted = 0, max_inflight = 0;
   int done_cnt = 0, stall_err = 0, stall_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        pend_rd = 1'b0;
   logic [15:0] pend_addr = '0;
   logic        cred_mode = 1'b0;
   logic [3:0]  cred_pat = 4'b1001;
   int          cidx = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, expv);
      end
   endtask

   // observe the router port and memory interface away from the rising edge
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!rx || data_i !== prev_data)) stall_err++;
         prev_stall = rx && !credit_o;
         if (prev_stall) stall_cnt++;
         prev_data = data_i;
         if (rx && credit_o) begin
            flits.push_back(data_i);
            flit_cyc.push_back(cyc);
            accepted++;
         end
         if (mem_rd) begin
            rd_log.push_back(mem_addr);
            issued++;
         end
         if (done) done_cnt++;
         if (issued - accepted > max_inflight) max_inflight = issued - accepted;
      end
      pend_rd   = mem_rd && !reset;
      pend_addr = mem_addr;
   end

   always @(posedge clock) begin
      #1;
      mem_data = pend_rd ? mem[pend_addr] : 32'hDEAD_BEEF;
   end

   always @(posedge clock) begin
      #1;
      if (cred_mode) begin
         credit_o = cred_pat[cidx];
         cidx = (cidx + 1) % 4;
      end else begin
         credit_o = 1'b1;
      end
   end

   task automatic clear_mon();
      flits.delete();
      flit_cyc.delete();
      rd_log.delete();
      issued = 0;
      accepted = 0;
      max_inflight = 0;
      done_cnt = 0;
      stall_err = 0;
      stall_cnt = 0;
   endtask

   task automatic start_pkt(input logic [15:0] base);
      @(posedge clock); #1;
      start = 1'b1;
      base_addr = base;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      for (n = 0; n < 300; n++) begin
         @(negedge clock); #1;
         if (done_cnt >= 1) break;
      end
      if (n >= 300) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic cmp_flits(input string tag);
      logic [31:0] got;
      chk({tag, "_nflits"}, 32'(flits.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < flits.size()) ? flits[i] : 32'hBAD0_BAD0;
         chk($sformatf("%s_flit%0d", tag, i), got, exp_q[i]);
      end
   endtask

   initial begin
      int lat;
      int n;
      logic seen300;
      for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
      mem[16'h0010] = 32'hA5; mem[16'h0011] = 32'd3;
      mem[16'h0012] = 32'h1;  mem[16'h0013] = 32'h2; mem[16'h0014] = 32'h3;
      mem[16'h0040] = 32'h1234_5678; mem[16'h0041] = 32'hFFFF_0000;
      mem[16'h0100] = 32'h00C0_FFEE; mem[16'h0101] = 32'd8;
      for (int i = 0; i < 8; i++) mem[16'h0102 + i] = 32'hF000_0000 + i;
      mem[16'hFFFE] = 32'hBEEF_0001; mem[16'hFFFF] = 32'd2;
      mem[16'h0000] = 32'h1111_1111; mem[16'h0001] = 32'h2222_2222;
      mem[16'h0200] = 32'h5A5A_0000; mem[16'h0201] = 32'd5;
      for (int i = 0; i < 5; i++) mem[16'h0202 + i] = 32'h50 + i;
      mem[16'h0300] = 32'h3333_0001; mem[16'h0301] = 32'd1; mem[16'h0302] = 32'hCAFE_F00D;

      repeat (2) @(negedge clock);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_rx", 32'(rx), 32'd0);
      chk("rst_data_i", data_i, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // basic packet, full credit
      clear_mon();
      exp_q = '{32'hA5, 32'h3, 32'h1, 32'h2, 32'h3};
      start_pkt(16'h0010);
      lat = 99;
      for (n = 1; n <= 10; n++) begin
         @(negedge clock); #1;
         if (rx) begin lat = n; break; end
      end
      chk("t1_latency_le3", 32'(lat <= 3), 32'd1);
      wait_done("t1");
      @(negedge clock); #1;
      chk("t1_busy_after", 32'(busy), 32'd0);
      cmp_flits("t1");
      chk("t1_contig", 32'((flit_cyc.size() == 5) ? flit_cyc[4] - flit_cyc[2] : -1), 32'd2);
      chk("t1_done_cnt", 32'(done_cnt), 32'd1);

      // zero-length payload; size word forwarded untouched
      clear_mon();
      exp_q = '{32'h1234_5678, 32'hFFFF_0000};
      start_pkt(16'h0040);
      wait_done("t2");
      repeat (2) @(negedge clock);
      cmp_flits("t2");
      chk("t2_nreads", 32'(rd_log.size()), 32'd2);
      chk("t2_done_cnt", 32'(done_cnt), 32'd1);

      // back-pressure 1,0,0,1 on an 8-word payload
      clear_mon();
      cidx = 0;
      cred_mode = 1'b1;
      exp_q = '{32'h00C0_FFEE, 32'd8};
      for (int i = 0; i < 8; i++) exp_q.push_back(32'hF000_0000 + i);
      start_pkt(16'h0100);
      wait_done("t3");
      @(negedge clock); #1;
      cred_mode = 1'b0;
      cmp_flits("t3");
      chk("t3_stall_stable", 32'(stall_err), 32'd0);
      chk("t3_stalls_seen", 32'(stall_cnt > 0), 32'd1);
      chk("t3_occupancy_le_depth", 32'(max_inflight <= 4), 32'd1);
      chk("t3_done_cnt", 32'(done_cnt), 32'd1);

      // address wrap
      clear_mon();
      exp_q = '{32'hBEEF_0001, 32'd2, 32'h1111_1111, 32'h2222_2222};
      start_pkt(16'hFFFE);
      wait_done("t4");
      @(negedge clock); #1;
      chk("t4_nreads", 32'(rd_log.size()), 32'd4);
      chk("t4_rd0", 32'((rd_log.size() > 0) ? rd_log[0] : 16'h5555), 32'h0000_FFFE);
      chk("t4_rd1", 32'((rd_log.size() > 1) ? rd_log[1] : 16'h5555), 32'h0000_FFFF);
      chk("t4_rd2", 32'((rd_log.size() > 2) ? rd_log[2] : 16'h5555), 32'h0000_0000);
      chk("t4_rd3", 32'((rd_log.size() > 3) ? rd_log[3] : 16'h5555), 32'h0000_0001);
      cmp_flits("t4");

      // start while busy is ignored, then reset mid-packet
      clear_mon();
      start_pkt(16'h0200);
      @(posedge clock); #1;
      start = 1'b1;
      base_addr = 16'h0300;
      @(posedge clock); #1;
      start = 1'b0;
      for (n = 0; n < 100; n++) begin
         @(negedge clock); #1;
         if (accepted >= 3) break;
      end
      if (n >= 100) chk("t5_timeout", 32'd0, 32'd1);
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      chk("t5_rx_in_reset", 32'(rx), 32'd0);
      chk("t5_busy_in_reset", 32'(busy), 32'd0);
      seen300 = 1'b0;
      foreach (rd_log[i]) if (rd_log[i] >= 16'h0300) seen300 = 1'b1;
      chk("t5_busy_start_ignored", 32'(seen300), 32'd0);
      chk("t5_flit0", (flits.size() > 0) ? flits[0] : 32'hBAD0_BAD0, 32'h5A5A_0000);
      chk("t5_flit1", (flits.size() > 1) ? flits[1] : 32'hBAD0_BAD0, 32'd5);
      chk("t5_flit2", (flits.size() > 2) ? flits[2] : 32'hBAD0_BAD0, 32'h50);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // fresh packet after the abandoned one
      clear_mon();
      exp_q = '{32'h3333_0001, 32'd1, 32'hCAFE_F00D};
      start_pkt(16'h0300);
      wait_done("t6");
      repeat (2) @(negedge clock);
      cmp_flits("t6");
      chk("t6_nreads", 32'(rd_log.size()), 32'd3);
      chk("t6_done_cnt", 32'(done_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ddma_packet_sender.md
DDMA_PACKET_SENDER -- requirements
Module: ddma_packet_sender

Interface
REQ-001 Parameter FLIT_WIDTH, default 32, width of every flit and memory word.
REQ-002 Parameter ADDR_WIDTH, default 16, local memory word-address width.
REQ-003 Parameter FIFO_DEPTH, default 4, prefetch buffer depth in flits (power of two, >=2).
REQ-004 Port clock  input  1  sole clock; one clock, all state on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  request to send one packet; sampled only in IDLE.
REQ-007 Port base_addr  input  ADDR_WIDTH  memory address of the packet header word; sampled with start.
REQ-008 Port busy  output  1  high whenever the FSM is not IDLE.
REQ-009 Port done  output  1  one-cycle pulse after the last flit is accepted by the router.
REQ-010 Port mem_rd  output  1  memory read strobe.
REQ-011 Port mem_addr  output  ADDR_WIDTH  memory read address.
REQ-012 Port mem_data  input  FLIT_WIDTH  read data, valid exactly one cycle after mem_rd.
REQ-013 Port clock_rx  output  1  router input-port clock; driven directly from clock.
REQ-014 Port rx  output  1  flit valid towards the router input port.
REQ-015 Port data_i  output  FLIT_WIDTH  flit towards the router input port.
REQ-016 Port credit_o  input  1  router input buffer can accept a flit this cycle.

Function
REQ-017 Packet in memory: word base_addr = header, base_addr+1 = size word (payload count N = low SIZE_WIDTH bits), then N payload words; 2+N flits sent in that order.
REQ-018 FSM states IDLE, FETCH_HDR, WAIT_SIZE, FETCH_PAYLOAD, DRAIN, DONE.
REQ-019 IDLE -> FETCH_HDR when start=1; start while busy is ignored with no side effect.
REQ-020 FETCH_HDR issues reads of base_addr and base_addr+1, then WAIT_SIZE until the size word returns and N is captured.
REQ-021 WAIT_SIZE -> FETCH_PAYLOAD if N>0, else DRAIN; FETCH_PAYLOAD -> DRAIN after the Nth payload read issued.
REQ-022 DRAIN -> DONE in the cycle the last flit is accepted; DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-023 A read is issued only if FIFO occupancy plus outstanding reads < FIFO_DEPTH; no FIFO overflow ever.
REQ-024 Memory addresses increment by 1 modulo 2^ADDR_WIDTH (wrap permitted).
REQ-025 rx = FIFO not empty; data_i = FIFO head; a flit is transferred on a rising edge with rx=1 and credit_o=1.
REQ-026 While rx=1 and credit_o=0, rx and data_i SHALL hold stable; no flit is dropped or duplicated.
REQ-027 Simultaneous FIFO push and pop in one cycle SHALL both take effect, occupancy unchanged.
REQ-028 Latency: with credit_o=1, rx rises no later than 3 cycles after start is sampled; payload flits are sent back-to-back with no bubble.
REQ-029 Flits are forwarded unmodified; the block does not interpret the header.

Reset
REQ-030 Reset asserted SHALL immediately force FSM=IDLE, FIFO empty, outstanding count 0.
REQ-031 Reset values: busy=0, done=0, mem_rd=0, mem_addr=0, rx=0, data_i=0.
REQ-032 Reset mid-packet SHALL abandon the packet; read data arriving after reset release is discarded.

Structure
REQ-033 Shared package ddma_pkg SHALL hold SIZE_WIDTH (16), the FSM state enum and default FLIT_WIDTH/FIFO_DEPTH constants.
REQ-034 Prefetch buffer SHALL be a sub-module ddma_flit_fifo (synchronous FIFO, push/pop/full/empty/count).
REQ-035 Implementation SHALL be 120-400 lines of RTL total.

Verification
REQ-036 base=0x10, mem[0x10]=0xA5, mem[0x11]=3, payload 0x1..0x3, credit_o=1 -> flits A5,3,1,2,3 with payload contiguous; done pulses once; busy low next cycle.
REQ-037 N=0 -> exactly 2 flits (header, size), no payload reads issued, done pulses.
REQ-038 credit_o toggling 1,0,0,1,... during a N=8 packet -> data_i stable while stalled, all 10 flits in order, FIFO never exceeds FIFO_DEPTH.
REQ-039 base=0xFFFE, ADDR_WIDTH=16, N=2 -> reads 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-040 start pulsed while busy -> ignored; reset asserted after flit 3 of N=5 -> rx=0, busy=0 immediately; new packet afterwards sent correctly.
